sound_scheduler: RTL and testbench

Arbitrates the game's three sound requests (`hit`, `wall`, `goal`) onto the single piezo/speaker output and sequences the tone pattern for each event. It sits between `game_controller` and the speaker pin and replaces direct event-to-tone driving. Simultaneous or overlapping events are latched, prioritised and played back-to-back, and a goal preempts a paddle or wall tone.

---
 rtl/sound_pkg.sv | 43 ++++
 rtl/tone_gen.sv | 45 ++++
 rtl/sound_scheduler.sv | 148 ++++++++++++++
 tb/tb_sound_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the speaker sound scheduler: FSM states,
// event encoding, counter widths and default tone timings.
package sound_pkg;

  localparam int HP_W       = 17;
  localparam int DUR_W      = 23;
  localparam int MELODY_LEN = 3;

  localparam int unsigned DEF_HP_WALL  = 113636;
  localparam int unsigned DEF_HP_HIT   = 56818;
  localparam int unsigned DEF_HP_G0    = 47801;
  localparam int unsigned DEF_HP_G1    = 37936;
  localparam int unsigned DEF_HP_G2    = 31888;
  localparam int unsigned DEF_NOTE_CYC = 5000000;
  localparam int unsigned DEF_GAP_CYC  = 1000000;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_WALL = 2'd1,
    EVT_HIT  = 2'd2,
    EVT_GOAL = 2'd3
  } evt_t;

  // Pending vectors are packed {goal, hit, wall}.
  function automatic evt_t pick_evt(input logic [2:0] pend);
    if (pend[2])      return EVT_GOAL;
    else if (pend[1]) return EVT_HIT;
    else if (pend[0]) return EVT_WALL;
    else              return EVT_NONE;
  endfunction

  function automatic logic [2:0] evt_mask(input evt_t e);
    case (e)
      EVT_WALL: return 3'b001;
      EVT_HIT:  return 3'b010;
      EVT_GOAL: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: sq toggles every half_period cycles while en is high,
// and restarts high whenever en rises or the half-period changes.
module tone_gen
  import sound_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HP_W-1:0] half_period,
  output logic            sq
);

  logic [HP_W-1:0] cnt_q;
  logic [HP_W-1:0] hp_q;
  logic            en_q;
  logic            sq_q;

  // en and half_period are next-cycle values, so sq lines up with the FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      hp_q  <= '0;
      en_q  <= 1'b0;
      sq_q  <= 1'b0;
    end else begin
      en_q <= en;
      hp_q <= half_period;
      if (!en) begin
        sq_q  <= 1'b0;
        cnt_q <= '0;
      end else if (!en_q || (half_period != hp_q)) begin
        sq_q  <= 1'b1;
        cnt_q <= half_period - 1'b1;
      end else if (cnt_q == '0) begin
        sq_q  <= ~sq_q;
        cnt_q <= half_period - 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/sound_scheduler.sv
// Latches hit/wall/goal sound requests, grants them by priority (goal > hit > wall)
// and sequences each event's notes and gaps onto the single speaker output.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned HP_WALL  = DEF_HP_WALL,
  parameter int unsigned HP_HIT   = DEF_HP_HIT,
  parameter int unsigned HP_G0    = DEF_HP_G0,
  parameter int unsigned HP_G1    = DEF_HP_G1,
  parameter int unsigned HP_G2    = DEF_HP_G2,
  parameter int unsigned NOTE_CYC = DEF_NOTE_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [1:0] active_evt
);

  localparam int unsigned HP_LIM  = 1 << HP_W;
  localparam int unsigned DUR_LIM = 1 << DUR_W;

  if (HP_WALL == 0 || HP_WALL >= HP_LIM || HP_HIT == 0 || HP_HIT >= HP_LIM ||
      HP_G0 == 0 || HP_G0 >= HP_LIM || HP_G1 == 0 || HP_G1 >= HP_LIM ||
      HP_G2 == 0 || HP_G2 >= HP_LIM) begin : g_bad_hp
    $error("sound_scheduler: half-period parameter out of range for %0d-bit counter", HP_W);
  end
  if (NOTE_CYC == 0 || NOTE_CYC > DUR_LIM || GAP_CYC == 0 || GAP_CYC > DUR_LIM) begin : g_bad_dur
    $error("sound_scheduler: duration parameter out of range for %0d-bit counter", DUR_W);
  end

  localparam logic [DUR_W-1:0] NOTE_RLD  = DUR_W'(NOTE_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_RLD   = DUR_W'(GAP_CYC - 1);
  localparam logic [1:0]       LAST_NOTE = 2'(MELODY_LEN - 1);

  logic [2:0]       req_q, rise;
  logic [2:0]       pend_q, pend_d;
  state_t           state_q, state_d;
  evt_t             evt_q, evt_d, grant;
  logic [1:0]       note_q, note_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             start, preempt;
  logic [HP_W-1:0]  hp_d;
  logic             sq;

  always_comb begin
    rise    = {goal, hit, wall} & ~req_q;
    grant   = pick_evt(pend_q);
    preempt = (evt_q != EVT_GOAL) && pend_q[2];
    start   = 1'b0;
    state_d = state_q;
    evt_d   = evt_q;
    note_d  = note_q;
    dur_d   = dur_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: start = (grant != EVT_NONE);
      TONE: begin
        if (preempt) begin
          start = 1'b1;
        end else if (dur_q == '0) begin
          state_d = GAP;
          dur_d   = GAP_RLD;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      GAP: begin
        if (preempt) begin
          start = 1'b1;
        end else if (dur_q != '0) begin
          dur_d = dur_q - 1'b1;
        end else if (evt_q == EVT_GOAL && note_q != LAST_NOTE) begin
          state_d = TONE;
          note_d  = note_q + 1'b1;
          dur_d   = NOTE_RLD;
        end else if (grant != EVT_NONE) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
          evt_d   = EVT_NONE;
          note_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant (fresh or preempting) always begins at note 0 with a full tone.
    if (start) begin
      state_d = TONE;
      evt_d   = grant;
      note_d  = '0;
      dur_d   = NOTE_RLD;
      pend_d  = pend_q & ~evt_mask(grant);
    end
    pend_d = pend_d | rise;
  end

  always_comb begin
    case (evt_d)
      EVT_WALL: hp_d = HP_W'(HP_WALL);
      EVT_HIT:  hp_d = HP_W'(HP_HIT);
      EVT_GOAL: begin
        case (note_d)
          2'd0:    hp_d = HP_W'(HP_G0);
          2'd1:    hp_d = HP_W'(HP_G1);
          default: hp_d = HP_W'(HP_G2);
        endcase
      end
      default:  hp_d = HP_W'(HP_WALL);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      evt_q   <= EVT_NONE;
      note_q  <= '0;
      dur_q   <= '0;
    end else begin
      req_q   <= {goal, hit, wall};
      pend_q  <= pend_d;
      state_q <= state_d;
      evt_q   <= evt_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (state_d == TONE),
    .half_period (hp_d),
    .sq          (sq)
  );

  assign sound      = sq & ~mute;
  assign busy       = (state_q != IDLE);
  assign active_evt = evt_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: a segment-list model of the sound timeline checked
// every cycle, plus directed scenarios with hand-computed totals.
module tb_sound_scheduler;

  localparam int HPW = 8;
  localparam int HPH = 4;
  localparam int G0  = 3;
  localparam int G1  = 5;
  localparam int G2  = 7;
  localparam int NC  = 40;
  localparam int GC  = 10;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       hit  = 1'b0;
  logic       wall = 1'b0;
  logic       goal = 1'b0;
  logic       mute = 1'b0;
  logic       sound;
  logic       busy;
  logic [1:0] active_evt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_scheduler #(
    .HP_WALL (HPW), .HP_HIT (HPH), .HP_G0 (G0), .HP_G1 (G1), .HP_G2 (G2),
    .NOTE_CYC(NC),  .GAP_CYC(GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hit        (hit),
    .wall       (wall),
    .goal       (goal),
    .mute       (mute),
    .sound      (sound),
    .busy       (busy),
    .active_evt (active_evt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Model: each granted event becomes a list of (tone|silence, half-period, length) segments.
  typedef struct {
    bit tone;
    int hp;
    int len;
  } seg_t;

  seg_t       segs[$];
  logic [2:0] m_pend = '0;
  logic [2:0] m_prev = '0;
  int         m_evt  = 0;
  int         m_off  = 0;

  function automatic void push_note(input int hp);
    segs.push_back('{1'b1, hp, NC});
    segs.push_back('{1'b0, 0, GC});
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [2:0] cur, rise, old;
    if (!rst) begin
      segs.delete();
      m_pend = '0;
      m_prev = '0;
      m_evt  = 0;
      m_off  = 0;
    end else begin
      cur    = {goal, hit, wall};
      rise   = cur & ~m_prev;
      m_prev = cur;
      old    = m_pend;
      if (segs.size() > 0) begin
        m_off++;
        if (m_off == segs[0].len) begin
          segs.delete(0);
          m_off = 0;
        end
      end
      if (segs.size() > 0 && m_evt != 3 && old[2]) begin
        segs.delete();
        m_off = 0;
      end
      if (segs.size() == 0) begin
        m_evt = 0;
        m_off = 0;
        if (old[2]) begin
          m_evt = 3; push_note(G0); push_note(G1); push_note(G2); m_pend[2] = 1'b0;
        end else if (old[1]) begin
          m_evt = 2; push_note(HPH); m_pend[1] = 1'b0;
        end else if (old[0]) begin
          m_evt = 1; push_note(HPW); m_pend[0] = 1'b0;
        end
      end
      m_pend = m_pend | rise;
    end
  end

  int busy_cnt = 0;
  int hi_cnt   = 0;
  int evt_cnt[4];

  task automatic clear_stats();
    busy_cnt = 0;
    hi_cnt   = 0;
    for (int i = 0; i < 4; i++) evt_cnt[i] = 0;
  endtask

  always @(negedge clk) begin : compare
    int  e_busy, e_evt, e_hi;
    e_busy = (segs.size() > 0) ? 1 : 0;
    e_evt  = m_evt;
    e_hi   = 0;
    if (segs.size() > 0) begin
      if (segs[0].tone && ((m_off / segs[0].hp) % 2 == 0)) e_hi = 1;
    end
    chk("cyc_busy", int'(busy), e_busy);
    chk("cyc_evt", int'(active_evt), e_evt);
    chk("cyc_sound", int'(sound), e_hi & int'(~mute));
    if (busy) busy_cnt++;
    if (sound) hi_cnt++;
    evt_cnt[active_evt]++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    clear_stats();
    step(3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sound", int'(sound), 0);
    chk("reset_evt", int'(active_evt), 0);
    rst = 1'b1;
    step(3);

    // Single hit pulse, rise sampled at edge k.
    clear_stats();
    hit = 1'b1; step(1); hit = 1'b0;
    step(1);
    chk("hit_k1_busy", int'(busy), 1);
    chk("hit_k1_sound", int'(sound), 1);
    chk("hit_k1_evt", int'(active_evt), 2);
    step(4);
    chk("hit_k5_sound", int'(sound), 0);
    step(45);
    chk("hit_k50_busy", int'(busy), 1);
    step(1);
    chk("hit_k51_busy", int'(busy), 0);
    step(5);
    chk("hit_busy_total", busy_cnt, 50);
    chk("hit_evt_total", evt_cnt[2], 50);
    chk("hit_high_total", hi_cnt, 20);

    // All three requests in the same cycle.
    clear_stats();
    hit = 1'b1; wall = 1'b1; goal = 1'b1; step(1);
    hit = 1'b0; wall = 1'b0; goal = 1'b0;
    step(260);
    chk("all_busy_total", busy_cnt, 250);
    chk("all_goal_total", evt_cnt[3], 150);
    chk("all_hit_total", evt_cnt[2], 50);
    chk("all_wall_total", evt_cnt[1], 50);
    chk("all_high_total", hi_cnt, 106);

    // Goal preempts a wall tone 15 cycles in.
    clear_stats();
    wall = 1'b1; step(1); wall = 1'b0;
    step(15);
    goal = 1'b1; step(1); goal = 1'b0;
    step(1);
    chk("pre_goal_evt", int'(active_evt), 3);
    chk("pre_goal_sound", int'(sound), 1);
    step(200);
    chk("pre_wall_total", evt_cnt[1], 16);
    chk("pre_goal_total", evt_cnt[3], 150);
    chk("pre_busy_total", busy_cnt, 166);

    // Three hit pulses during one melody collapse into one hit note.
    clear_stats();
    goal = 1'b1; step(1); goal = 1'b0;
    step(19);
    hit = 1'b1; step(1); hit = 1'b0;
    step(40);
    hit = 1'b1; step(1); hit = 1'b0;
    step(50);
    hit = 1'b1; step(1); hit = 1'b0;
    step(120);
    chk("multi_hit_total", evt_cnt[2], 50);
    chk("multi_goal_total", evt_cnt[3], 150);
    chk("multi_busy_total", busy_cnt, 200);

    // Muted hit note.
    mute = 1'b1;
    clear_stats();
    hit = 1'b1; step(1); hit = 1'b0;
    step(60);
    chk("mute_busy_total", busy_cnt, 50);
    chk("mute_evt_total", evt_cnt[2], 50);
    chk("mute_high_total", hi_cnt, 0);
    mute = 1'b0;
    step(2);

    // Reset in the middle of G1 with a wall pending.
    clear_stats();
    goal = 1'b1; step(1); goal = 1'b0;
    step(59);
    wall = 1'b1; step(1); wall = 1'b0;
    step(11);
    chk("rst_pre_sound", int'(sound), 1);
    chk("rst_pre_evt", int'(active_evt), 3);
    rst = 1'b0;
    #1;
    chk("rst_mid_sound", int'(sound), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_evt", int'(active_evt), 0);
    step(2);
    rst = 1'b1;
    clear_stats();
    step(100);
    chk("rst_after_busy", busy_cnt, 0);
    chk("rst_after_wall", evt_cnt[1], 0);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
